// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU read sequencer: FSM states, sensor init words, rate register map.
package imu_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_WR,
        INIT_WAIT,
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        PUBLISH
    } state_e;

    localparam int NUM_INIT = 4;
    localparam int NUM_RD   = 6;

    // Element 0 is issued first: INT enable, accel cfg, gyro cfg, rounding.
    localparam logic [NUM_INIT-1:0][15:0] INIT_TBL = {16'h1460, 16'h1150, 16'h1053, 16'h0D02};

    // ptchL/H, rollL/H, yawL/H; byte slot n is filled from RD_ADDR[n].
    localparam logic [NUM_RD-1:0][6:0] RD_ADDR = {7'h27, 7'h26, 7'h25, 7'h24, 7'h23, 7'h22};

    function automatic logic [15:0] rd_cmd(input logic [2:0] idx);
        return {1'b1, RD_ADDR[idx], 8'h00};
    endfunction

endpackage

// File: rtl/imu_rd_seq_if.sv
// Command/response link between the IMU sequencer (master) and the 16-bit SPI master (slave).
interface imu_rd_seq_if;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;

    modport master (
        output spi_wrt,
        output spi_cmd,
        input  spi_done,
        input  spi_rd_data
    );

    modport slave (
        input  spi_wrt,
        input  spi_cmd,
        output spi_done,
        output spi_rd_data
    );
endinterface

// File: rtl/imu_int_sync.sv
// Two-flop synchronizer for the sensor INT line plus a one-cycle rising-edge pulse.
// Edge pulse appears 2 clks after the input rises; no backpressure.
module imu_int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/imu_rd_seq.sv
// IMU sequencer: power-up wait, sensor config writes, then six-byte rate reads per INT; vld 1 clk after 6th spi_done.
// One SPI transaction outstanding at a time; optional SPI watchdog and sticky err under IMU_TIMEOUT_EN.
module imu_rd_seq
    import imu_pkg::*;
#(
    parameter int PWRUP_CYC   = 65536,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         INT,
    imu_rd_seq_if.master spi,
    output logic [15:0]  ptch,
    output logic [15:0]  roll,
    output logic [15:0]  yaw,
    output logic         vld,
    output logic         err
);

    localparam int PW = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
    localparam logic [PW-1:0] PWR_LAST  = PW'(PWRUP_CYC - 1);
    localparam logic [2:0]    INIT_LAST = 3'(NUM_INIT - 1);
    localparam logic [2:0]    RD_LAST   = 3'(NUM_RD - 1);

    state_e                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [PW-1:0]            pwr_cnt_q, pwr_cnt_d;
    logic                     pend_q, pend_d;
    logic [NUM_RD-1:0][7:0]   hold_q, hold_d;
    logic [15:0]              ptch_q, roll_q, yaw_q;
    logic                     vld_q;

    logic                     int_rise;
    logic                     armed;
    logic                     waiting;
    logic                     start_rd;
    logic                     publish;
    logic                     wrt_c;
    logic [15:0]              cmd_c;
    logic                     to_fire;
    logic                     unused_rd_hi;

    imu_int_sync u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (INT),
        .rise_o  (int_rise)
    );

    // INT edges only count once the sensor has been configured.
    assign armed   = !(state_q inside {PWR_WAIT, INIT_WR, INIT_WAIT});
    assign waiting = (state_q == INIT_WAIT) || (state_q == RD_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PWR_WAIT;
            idx_q     <= '0;
            pwr_cnt_q <= '0;
            pend_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pwr_cnt_q <= pwr_cnt_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pwr_cnt_d = pwr_cnt_q;
        pend_d    = pend_q;
        hold_d    = hold_q;
        wrt_c     = 1'b0;
        cmd_c     = '0;
        publish   = 1'b0;
        start_rd  = 1'b0;

        unique case (state_q)
            PWR_WAIT: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = INIT_WR;
                    idx_d   = '0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PW'(1);
                end
            end
            INIT_WR: begin
                wrt_c   = 1'b1;
                cmd_c   = INIT_TBL[idx_q[1:0]];
                state_d = INIT_WAIT;
            end
            INIT_WAIT: begin
                cmd_c = INIT_TBL[idx_q[1:0]];
                if (spi.spi_done) begin
                    if (idx_q == INIT_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = INIT_WR;
                        idx_d   = idx_q + 3'd1;
                    end
                end else if (to_fire) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            IDLE: begin
                start_rd = pend_q;
            end
            RD_ISSUE: begin
                wrt_c   = 1'b1;
                cmd_c   = rd_cmd(idx_q);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cmd_c = rd_cmd(idx_q);
                if (spi.spi_done) begin
                    hold_d[idx_q] = spi.spi_rd_data[7:0];
                    if (idx_q == RD_LAST) begin
                        publish = 1'b1;
                        state_d = PUBLISH;
                        idx_d   = '0;
                    end else begin
                        state_d = RD_ISSUE;
                        idx_d   = idx_q + 3'd1;
                    end
                end else if (to_fire) begin
                    // A stalled read leaves a partial triple; drop it rather than publish.
                    state_d = IDLE;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            end
            PUBLISH: begin
                start_rd = pend_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase

        if (start_rd) begin
            state_d = RD_ISSUE;
            idx_d   = '0;
            pend_d  = 1'b0;
        end
        // A fresh edge wins over the clear so data-ready coincident with a start is not lost.
        if (int_rise && armed) begin
            pend_d = 1'b1;
        end
    end

    // The whole triple loads on the final byte, so consumers never see a mix of old and new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_q <= '0;
            roll_q <= '0;
            yaw_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= publish;
            if (publish) begin
                ptch_q <= {hold_d[1], hold_d[0]};
                roll_q <= {hold_d[3], hold_d[2]};
                yaw_q  <= {hold_d[5], hold_d[4]};
            end
        end
    end

`ifdef IMU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (wrt_c) begin
            to_cnt_d = TW'(TIMEOUT_CYC - 1);
        end else if (waiting && (to_cnt_q != '0)) begin
            to_cnt_d = to_cnt_q - TW'(1);
        end
        to_fire = waiting && !spi.spi_done && (to_cnt_q <= TW'(1));
        err_d   = err_q | to_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_cfg;

    assign to_fire            = 1'b0;
    assign err                = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0) & waiting;
`endif

    assign unused_rd_hi = ^spi.spi_rd_data[15:8];

    assign spi.spi_wrt = wrt_c;
    assign spi.spi_cmd = cmd_c;
    assign ptch        = ptch_q;
    assign roll        = roll_q;
    assign yaw         = yaw_q;
    assign vld         = vld_q;

endmodule

// File: tb/tb_imu_rd_seq.sv
// Bench for imu_rd_seq: SPI slave model answering 40 clks after wrt, command/result scoreboard queues.
module tb_imu_rd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic [15:0] ptch, roll, yaw;
    logic        vld, err;

    logic        m_done, m_stray;
    logic [15:0] m_rd, m_rd_next, m_cmd_hold;
    bit          busy, withhold;
    int          m_cnt;

    int n_tests, n_fail, n_wrt, n_vld;
    int cyc, first_wrt_cyc, last_done_cyc;

    logic [15:0] exp_cmd_q[$];
    logic [47:0] exp_res_q[$];
    logic [7:0]  byte_q[$];

    always #5 clk = ~clk;

    imu_rd_seq_if spi_if ();

    assign spi_if.spi_done    = m_done | m_stray;
    assign spi_if.spi_rd_data = m_rd;

    imu_rd_seq #(
        .PWRUP_CYC   (16),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .INT   (INT),
        .spi   (spi_if),
        .ptch  (ptch),
        .roll  (roll),
        .yaw   (yaw),
        .vld   (vld),
        .err   (err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        for (int i = 0; i < 6; i++) begin
            exp_cmd_q.push_back(16'hA200 + (16'(i) << 8));
        end
        byte_q.push_back(b0); byte_q.push_back(b1); byte_q.push_back(b2);
        byte_q.push_back(b3); byte_q.push_back(b4); byte_q.push_back(b5);
        exp_res_q.push_back({b1, b0, b3, b2, b5, b4});
    endtask

    task automatic push_init();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1053);
        exp_cmd_q.push_back(16'h1150);
        exp_cmd_q.push_back(16'h1460);
    endtask

    // which: 0 = spi_wrt, 1 = vld, 2 = err; returns at the negedge the signal is seen
    task automatic wait_for(input int which, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = spi_if.spi_wrt;
                1:       seen = vld;
                default: seen = err;
            endcase
        end
        check(tag, seen, 1);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // SPI slave model plus output monitor, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy   = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    busy          = 1'b0;
                    m_done        = 1'b1;
                    m_rd          = m_rd_next;
                    last_done_cyc = cyc;
                    check("cmd_hold", spi_if.spi_cmd, m_cmd_hold);
                end
            end
            if (spi_if.spi_wrt) begin
                n_wrt++;
                if (first_wrt_cyc < 0) first_wrt_cyc = cyc;
                check("wrt_while_busy", busy, 0);
                check("cmd_expected", exp_cmd_q.size() != 0, 1);
                if (exp_cmd_q.size() != 0) check("cmd", spi_if.spi_cmd, exp_cmd_q.pop_front());
                if (spi_if.spi_cmd[15] && byte_q.size() != 0) m_rd_next = {8'hA5, byte_q.pop_front()};
                else                                          m_rd_next = 16'hFFFF;
                m_cmd_hold = spi_if.spi_cmd;
                if (!withhold) begin
                    busy  = 1'b1;
                    m_cnt = 40;
                end
            end
            if (vld) begin
                n_vld++;
                check("vld_latency", cyc - last_done_cyc, 1);
                check("res_expected", exp_res_q.size() != 0, 1);
                if (exp_res_q.size() != 0) begin
                    logic [47:0] r;
                    r = exp_res_q.pop_front();
                    check("ptch", ptch, r[47:32]);
                    check("roll", roll, r[31:16]);
                    check("yaw",  yaw,  r[15:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, base;
        bit seen;
        n_tests = 0; n_fail = 0; n_wrt = 0; n_vld = 0;
        first_wrt_cyc = -1; last_done_cyc = 0;
        rst_n = 1'b0; INT = 1'b0; m_stray = 1'b0; withhold = 1'b0;
        m_rd = 16'h0; m_rd_next = 16'h0; m_cmd_hold = 16'h0; busy = 1'b0; m_done = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_wrt",  spi_if.spi_wrt, 0);
        check("rst_cmd",  spi_if.spi_cmd, 0);
        check("rst_vld",  vld, 0);
        check("rst_ptch", ptch, 0);
        check("rst_roll", roll, 0);
        check("rst_yaw",  yaw, 0);
        check("rst_err",  err, 0);

        // Power-up and init, with INT pulses during PWR_WAIT and during init writes.
        push_init();
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk); INT = 1'b1;
        repeat (3) @(negedge clk); INT = 1'b0;
        repeat (90) @(negedge clk); INT = 1'b1;
        repeat (3) @(negedge clk); INT = 1'b0;
        repeat (100) @(negedge clk);
        @(posedge clk);
        check("init_first_wrt", first_wrt_cyc, 16);
        check("init_wrt_cnt", n_wrt, 4);
        check("early_int_no_vld", n_vld, 0);

        // Stray spi_done in IDLE must not provoke anything.
        @(negedge clk) m_stray = 1'b1;
        @(negedge clk) m_stray = 1'b0;
        repeat (60) @(negedge clk);
        @(posedge clk);
        check("stray_done_wrt", n_wrt, 4);

        // Single read sequence.
        push_seq(8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A);
        @(negedge clk) INT = 1'b1;
        wait_for(1, 400, "rd1_vld_seen");
        @(negedge clk) INT = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        check("rd1_nvld", n_vld, 1);
        check("rd1_nwrt", n_wrt, 10);

        // Two extra INT edges during one sequence collapse to one follow-up sequence.
        push_seq(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
        push_seq(8'hF1, 8'h7F, 8'h00, 8'h80, 8'hFF, 8'hFF);
        @(negedge clk) INT = 1'b1;
        repeat (10) @(negedge clk); INT = 1'b0;
        repeat (60) @(negedge clk); INT = 1'b1;
        repeat (10) @(negedge clk); INT = 1'b0;
        repeat (50) @(negedge clk); INT = 1'b1;
        repeat (10) @(negedge clk); INT = 1'b0;
        wait_for(1, 400, "dbl_vld1_seen");
        @(negedge clk);
        check("dbl_restart_wrt", spi_if.spi_wrt, 1);
        wait_for(1, 400, "dbl_vld2_seen");
        repeat (300) @(negedge clk);
        @(posedge clk);
        check("dbl_nvld", n_vld, 3);
        check("dbl_nwrt", n_wrt, 22);

        // Reset while the third read is being issued.
        exp_cmd_q.push_back(16'hA200); exp_cmd_q.push_back(16'hA300); exp_cmd_q.push_back(16'hA400);
        byte_q.push_back(8'h01); byte_q.push_back(8'h02); byte_q.push_back(8'h03);
        @(negedge clk) INT = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = spi_if.spi_wrt && (spi_if.spi_cmd == 16'hA400);
        end
        check("rst3_seen", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_wrt",  spi_if.spi_wrt, 0);
        check("rstmid_cmd",  spi_if.spi_cmd, 0);
        check("rstmid_vld",  vld, 0);
        check("rstmid_ptch", ptch, 0);
        check("rstmid_roll", roll, 0);
        check("rstmid_yaw",  yaw, 0);
        exp_cmd_q.delete();
        byte_q.delete();
        INT = 1'b0;
        repeat (3) @(negedge clk);
        push_init();
        first_wrt_cyc = -1;
        base = n_wrt;
        @(negedge clk) rst_n = 1'b1;
        repeat (200) @(negedge clk);
        @(posedge clk);
        check("replay_first_wrt", first_wrt_cyc, 16);
        check("replay_nwrt", n_wrt - base, 4);

`ifdef IMU_TIMEOUT_EN
        // Withheld done: err after 64 clks, no vld, then a normal read.
        withhold = 1'b1;
        base = n_vld;
        exp_cmd_q.push_back(16'hA200);
        @(negedge clk) INT = 1'b1;
        wait_for(0, 20, "to_wrt_seen");
        w = cyc;
        wait_for(2, 200, "to_err_seen");
        check("to_err_cyc", cyc - w, 64);
        repeat (10) @(negedge clk);
        INT = 1'b0;
        withhold = 1'b0;
        check("to_err_sticky", err, 1);
        @(posedge clk);
        check("to_no_vld", n_vld, base);
        push_seq(8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0);
        repeat (5) @(negedge clk);
        INT = 1'b1;
        wait_for(1, 400, "to_rd_vld_seen");
        @(negedge clk) INT = 1'b0;
        check("to_err_hold", err, 1);
`else
        w = 0;
        check("err_tied_low", err, w);
`endif

        repeat (5) @(negedge clk);
        check("sb_cmd_empty", exp_cmd_q.size(), 0);
        check("sb_res_empty", exp_res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
